// File: rtl/uart_tx_mmio_if.sv
// Memory-port bundle between the multicycle core and the UART transmitter.
// The core drives address/wdata/we and samples the combinational rdata/hit.
interface uart_tx_mmio_if;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        hit;

    modport master (output address, output wdata, output we, input rdata, input hit);
    modport slave  (input address, input wdata, input we, output rdata, output hit);
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO, so firmware can
// queue bytes with plain stores and never stall the core.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_mmio_if.slave   bus,
    output logic            tx,
    output logic            irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             r_state, w_stateNext;
    logic [15:0]        r_baudCnt, w_baudNext;
    logic [2:0]         r_bitCnt, w_bitNext;
    logic [7:0]         r_shift, w_shiftNext;
    logic [15:0]        r_div, w_divNext;
    logic [15:0]        r_divisor;
    logic               r_overflow;
    logic [7:0]         r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr, r_rdPtr;
    logic [CNT_W-1:0]   r_count;

    logic [1:0]         w_offset;
    logic               w_hit, w_wrEn, w_pushReq, w_push, w_pop;
    logic               w_full, w_empty, w_busy, w_ovfSet, w_ovfClr;
    logic [15:0]        w_effDiv;
    logic [7:0]         w_fifoHead;
    logic [31:0]        w_countExt;
    logic [3:0]         w_countSat;
    logic [31:0]        w_rdata;

    assign w_offset   = bus.address[3:2];
    assign w_hit      = (bus.address[31:4] == BASE_ADDR[31:4]);
    assign w_wrEn     = bus.we & w_hit;
    assign w_pushReq  = w_wrEn & (w_offset == 2'd0);
    assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_busy     = (r_state != IDLE);
    // A full FIFO still accepts a byte when the transmitter frees a slot on the same edge.
    assign w_push     = w_pushReq & (~w_full | w_pop);
    assign w_ovfSet   = w_pushReq & w_full & ~w_pop;
    assign w_ovfClr   = w_wrEn & (w_offset == 2'd1) & bus.wdata[3];
    assign w_effDiv   = (r_divisor == 16'd0) ? 16'd1 : r_divisor;
    assign w_fifoHead = r_fifoMem[r_rdPtr];
    assign w_countExt = 32'(r_count);
    assign w_countSat = (w_countExt > 32'd15) ? 4'hF : w_countExt[3:0];

    assign bus.hit   = w_hit;
    assign bus.rdata = w_rdata;
    assign irq       = w_empty & ~w_busy;

    // Register read mux; zero outside the window and for write-only/reserved slots.
    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            case (w_offset)
                2'd1:    w_rdata = {24'd0, w_countSat, r_overflow, w_busy, w_empty, w_full};
                2'd2:    w_rdata = {16'd0, r_divisor};
                default: w_rdata = 32'd0;
            endcase
        end
    end

    // Serial line level is decoded from the frame state so reset forces it high at once.
    always_comb begin
        case (r_state)
            START:   tx = 1'b0;
            DATA:    tx = r_shift[0];
            default: tx = 1'b1;
        endcase
    end

    // Frame sequencer: pops a byte and latches the divisor at each frame start.
    always_comb begin
        w_stateNext = r_state;
        w_baudNext  = r_baudCnt;
        w_bitNext   = r_bitCnt;
        w_shiftNext = r_shift;
        w_divNext   = r_div;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shiftNext = w_fifoHead;
                    w_divNext   = w_effDiv;
                    w_baudNext  = w_effDiv - 16'd1;
                    w_bitNext   = 3'd0;
                    w_stateNext = START;
                end
            end
            START: begin
                if (r_baudCnt == 16'd0) begin
                    w_baudNext  = r_div - 16'd1;
                    w_bitNext   = 3'd0;
                    w_stateNext = DATA;
                end else begin
                    w_baudNext = r_baudCnt - 16'd1;
                end
            end
            DATA: begin
                if (r_baudCnt == 16'd0) begin
                    w_baudNext = r_div - 16'd1;
                    if (r_bitCnt == 3'd7) begin
                        w_stateNext = STOP;
                    end else begin
                        w_shiftNext = {1'b0, r_shift[7:1]};
                        w_bitNext   = r_bitCnt + 3'd1;
                    end
                end else begin
                    w_baudNext = r_baudCnt - 16'd1;
                end
            end
            STOP: begin
                if (r_baudCnt == 16'd0) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_fifoHead;
                        w_divNext   = w_effDiv;
                        w_baudNext  = w_effDiv - 16'd1;
                        w_bitNext   = 3'd0;
                        w_stateNext = START;
                    end else begin
                        w_stateNext = IDLE;
                    end
                end else begin
                    w_baudNext = r_baudCnt - 16'd1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Sequencer state and shift datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baudCnt <= 16'd0;
            r_bitCnt  <= 3'd0;
            r_shift   <= 8'd0;
            r_div     <= 16'd1;
        end else begin
            r_state   <= w_stateNext;
            r_baudCnt <= w_baudNext;
            r_bitCnt  <= w_bitNext;
            r_shift   <= w_shiftNext;
            r_div     <= w_divNext;
        end
    end

    // FIFO pointers, occupancy, and the software-visible control registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_divisor  <= DEFAULT_DIV;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_ovfSet)      r_overflow <= 1'b1;
            else if (w_ovfClr) r_overflow <= 1'b0;
            if (w_wrEn && w_offset == 2'd2) r_divisor <= bus.wdata[15:0];
        end
    end

    // FIFO storage needs no reset; occupancy alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_fifoMem[r_wrPtr] <= bus.wdata[7:0];
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for the memory-mapped UART transmitter.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    logic irq;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] rd;

    uart_tx_mmio_if bus();

    uart_tx_mmio #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .irq   (irq)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One store: presented at a falling edge, taken at the next rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.address = addr;
        bus.wdata   = data;
        bus.we      = 1'b1;
        @(posedge clk);
        #1;
        bus.we = 1'b0;
    endtask

    task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
        bus.address = addr;
        bus.we      = 1'b0;
        #1;
        data = bus.rdata;
    endtask

    // Expected line level i cycles into an 8N1 frame of byte b at div clocks/bit.
    function automatic logic frameBit(input logic [7:0] b, input int div, input int i);
        int k;
        k = i / div;
        if (k == 0) return 1'b0;
        else if (k <= 8) return b[k-1];
        else return 1'b1;
    endfunction

    initial begin
        reset       = 1'b1;
        bus.address = BASE + 32'd4;
        bus.wdata   = 32'd0;
        bus.we      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state and address decode.
        readReg(BASE + 32'd4, rd);
        checkOutput("rst_status", rd, 32'h0000_0002);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_irq", 32'(irq), 32'd1);
        checkOutput("rst_hit", 32'(bus.hit), 32'd1);
        readReg(BASE + 32'd8, rd);
        checkOutput("rst_div", rd, 32'd434);
        readReg(BASE + 32'd12, rd);
        checkOutput("rsvd_read", rd, 32'd0);
        applyStimulus(BASE + 32'd12, 32'hFFFF_FFFF);
        readReg(BASE + 32'd12, rd);
        checkOutput("rsvd_write", rd, 32'd0);
        readReg(BASE + 32'd8, rd);
        checkOutput("rsvd_div_keep", rd, 32'd434);

        // Single frame 0xA5 at 4 clocks/bit.
        applyStimulus(BASE + 32'd8, 32'd4);
        applyStimulus(BASE, 32'hA5);
        bus.address = BASE + 32'd4;
        @(posedge clk); #1;
        checkOutput("a5_irq_busy", 32'(irq), 32'd0);
        for (int i = 0; i < 40; i++) begin
            checkOutput($sformatf("a5_tx_%0d", i), 32'(tx), 32'(frameBit(8'hA5, 4, i)));
            checkOutput($sformatf("a5_busy_%0d", i), 32'(bus.rdata[2]), 32'd1);
            @(posedge clk); #1;
        end
        checkOutput("a5_busy_end", 32'(bus.rdata[2]), 32'd0);
        checkOutput("a5_irq_end", 32'(irq), 32'd1);
        checkOutput("a5_tx_end", 32'(tx), 32'd1);

        // Two bytes back to back at 2 clocks/bit with no idle gap.
        applyStimulus(BASE + 32'd8, 32'd2);
        applyStimulus(BASE, 32'h41);
        applyStimulus(BASE, 32'h42);
        bus.address = BASE + 32'd4;
        #1;
        for (int i = 0; i < 40; i++) begin
            checkOutput($sformatf("b2b_tx_%0d", i), 32'(tx),
                        32'((i < 20) ? frameBit(8'h41, 2, i) : frameBit(8'h42, 2, i - 20)));
            if (i == 5)  checkOutput("b2b_status_f1", bus.rdata, 32'h0000_0014);
            if (i == 25) checkOutput("b2b_status_f2", bus.rdata, 32'h0000_0006);
            @(posedge clk); #1;
        end
        checkOutput("b2b_idle", bus.rdata, 32'h0000_0002);

        // Overflow: ten stores at 100 clocks/bit, one popped, eight buffered, one dropped.
        applyStimulus(BASE + 32'd8, 32'd100);
        for (int k = 0; k < 10; k++) applyStimulus(BASE, 32'h10 + 32'(k));
        readReg(BASE + 32'd4, rd);
        checkOutput("ovf_status", rd, 32'h0000_008D);
        applyStimulus(BASE + 32'd4, 32'h8);
        readReg(BASE + 32'd4, rd);
        checkOutput("ovf_clear", rd, 32'h0000_0085);
        bus.address = BASE + 32'd16;
        #1;
        checkOutput("miss_hit", 32'(bus.hit), 32'd0);
        checkOutput("miss_rdata", bus.rdata, 32'd0);
        applyStimulus(BASE + 32'd16, 32'hEE);
        readReg(BASE + 32'd4, rd);
        checkOutput("miss_nochange", rd, 32'h0000_0085);

        // Abort in the middle of the data bits of byte 0x10.
        repeat (139) @(posedge clk);
        #1;
        checkOutput("abort_tx_data", 32'(tx), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_tx_async", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        readReg(BASE + 32'd4, rd);
        checkOutput("abort_status", rd, 32'h0000_0002);
        checkOutput("abort_irq", 32'(irq), 32'd1);

        // Divisor change mid-frame applies from the next frame.
        applyStimulus(BASE + 32'd8, 32'd4);
        applyStimulus(BASE, 32'h33);
        applyStimulus(BASE + 32'd8, 32'd8);
        applyStimulus(BASE, 32'h0F);
        bus.address = BASE + 32'd4;
        for (int i = 1; i < 120; i++) begin
            checkOutput($sformatf("div_tx_%0d", i), 32'(tx),
                        32'((i < 40) ? frameBit(8'h33, 4, i) : frameBit(8'h0F, 8, i - 40)));
            @(posedge clk); #1;
        end
        checkOutput("div_idle", bus.rdata, 32'h0000_0002);

        // Divisor 0 runs at 1 clock/bit.
        applyStimulus(BASE + 32'd8, 32'd0);
        readReg(BASE + 32'd8, rd);
        checkOutput("div0_read", rd, 32'd0);
        applyStimulus(BASE, 32'h96);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("div0_tx_%0d", i), 32'(tx), 32'(frameBit(8'h96, 1, i)));
            @(posedge clk); #1;
        end
        checkOutput("div0_irq", 32'(irq), 32'd1);
        checkOutput("div0_tx_idle", 32'(tx), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the downstream side of the core's memory port.
- Consumes the core's address / write-data / write-enable outputs and returns combinational read data on the core's data-in path.
- Buffers bytes in a small FIFO and serialises each byte 8N1 on a single tx line.
- Lets firmware print without stalling the multicycle core.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 16-byte register window.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, ≥2.
- DEFAULT_DIV, 16'd434, reset value of DIVISOR in clocks per bit.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- address  in  32  byte address from the core.
- wdata  in  32  store data from the core.
- we  in  1  store strobe, one cycle per store.
- rdata  out  32  combinational read data for the current address.
- hit  out  1  combinational; address[31:4] == BASE_ADDR[31:4].
- tx  out  1  serial output, idle high.
- irq  out  1  level interrupt: FIFO empty and transmitter idle.

Behaviour:
- Reset (asynchronous, active-high):
  - tx=1, FIFO empty, FSM=IDLE, DIVISOR=DEFAULT_DIV, overflow=0, irq=1.
  - rdata/hit follow address combinationally.
  - Reset mid-frame aborts the frame immediately: tx forced high, FIFO contents lost.
- Register map (offset = address[3:2]; address[1:0] ignored):
  - 0 TXDATA. Write: push wdata[7:0]. Read: 0.
  - 1 STATUS. Read bits: [0] full, [1] empty, [2] busy (FSM≠IDLE), [3] overflow (sticky), [7:4] FIFO count (saturating in 4 bits), others 0. Write 1 to bit3 clears overflow; other bits ignored.
  - 2 DIVISOR. Read/write [15:0]; upper bits read 0.
  - 3 reserved: reads 0, writes ignored.
- Address and read rules:
  - Writes act only when we=1 and hit=1.
  - Reads return 0 when hit=0.
  - Reads have zero latency: rdata reflects state before the current edge.
- FIFO:
  - Push when full drops the byte and sets overflow.
  - Push and pop on the same edge with the FIFO full: push accepted, count unchanged, overflow not set.
  - Push and pop on the same edge with the FIFO empty is impossible, since pop requires non-empty.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when the FIFO is non-empty, pop on that edge, load the shift register, latch effective divisor = max(DIVISOR,1), go to START.
  - START: tx=0 for div cycles.
  - DATA: 8 bits LSB first, each held div cycles; 3-bit bit counter.
  - STOP: tx=1 for div cycles.
  - STOP exit: if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap); else IDLE.
  - Frame length is exactly 10*div cycles.
- Latency: a TXDATA write at edge E0 into an idle, empty block makes tx fall at edge E1.
- DIVISOR write during a frame takes effect at the next frame start. DIVISOR=0 behaves as 1.
- Baud counter is 16 bits. It reloads at each bit boundary and counts div-1 down to 0.
- irq = empty & ~busy, combinational from registered state.

Test Plan:
- Reset release, read STATUS at BASE+4 -> rdata=32'h0000_0002; tx=1; irq=1; read BASE+8 -> 434.
- DIVISOR=4, write 8'hA5 to BASE+0 at edge E0 -> tx low from E1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; busy=1 for exactly 40 cycles; irq returns to 1.
- DIVISOR=2, write 8'h41, 8'h42 on consecutive cycles -> two frames of 20 cycles each with no idle cycle between; STATUS count reads 1 during the first frame.
- DIVISOR=100, write 10 bytes back to back:
  - 1 popped, 8 buffered, 1 dropped; STATUS shows full=1, overflow=1.
  - Writing 32'h8 to BASE+4 clears overflow only.
- Write DIVISOR=8 mid-frame at DIVISOR=4 -> current frame finishes at 4 clocks/bit, next frame at 8; DIVISOR=0 -> 1 clock/bit (10-cycle frame).
- Boundaries:
  - Assert reset mid-DATA -> tx=1 asynchronously, STATUS=2 after release.
  - Store to BASE+16 -> hit=0, no FIFO change.
  - Read BASE+12 -> 0.
